// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - RAW scoreboard, stall and branch-flush sequencer (option: HAZARD_STATS_EN)
`ifndef REGAW
`define REGAW 4
`endif

module hazard_ctrl #(
  parameter int NREGS        = 16,
  parameter int CNTW         = 2,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid_in,
  input  logic [`REGAW-1:0] rn_a_in,
  input  logic [`REGAW-1:0] rm_a_in,
  input  logic [`REGAW-1:0] rd_a_in,
  input  logic              use_rn_in,
  input  logic              use_rm_in,
  input  logic              use_rd_in,
  input  logic              reg_we_in,
  input  logic              retire_valid_in,
  input  logic [`REGAW-1:0] retire_wa_in,
  input  logic              retire_had_we_in,
  input  logic              branch_taken_in,
  output logic              stall_out,
  output logic              flush_out,
  output logic              issue_fire_out,
  output logic [15:0]       stall_cnt_out,
  output logic [15:0]       flush_cnt_out
);

  localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};
  localparam logic [2:0]      FC_LOAD = 3'(FLUSH_CYCLES - 1);

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t          state_q, state_d;
  logic [2:0]      fc_q, fc_d;
  logic            flush_load;
  logic [CNTW-1:0] cnt_q [NREGS];
  logic [NREGS-1:0] inc, dec;
  logic            haz;

  // Flush window is a pure function of the registered state, so it never glitches
  assign flush_out = (state_q == FLUSH);

  // RAW hazard on any used source, or WAW when the destination counter is full
  always_comb begin
    haz = issue_valid_in &
          ((use_rn_in & (cnt_q[rn_a_in] != '0)) |
           (use_rm_in & (cnt_q[rm_a_in] != '0)) |
           (use_rd_in & (cnt_q[rd_a_in] != '0)) |
           (reg_we_in & (cnt_q[rd_a_in] == CNT_MAX)));
  end

  assign stall_out      = haz & ~flush_out;
  assign issue_fire_out = issue_valid_in & ~stall_out & ~flush_out;

  // Per-register increment/decrement requests from issue and retire
  always_comb begin
    inc = '0;
    dec = '0;
    for (int r = 0; r < NREGS; r++) begin
      inc[r] = issue_fire_out & reg_we_in & (rd_a_in == `REGAW'(r));
      dec[r] = retire_valid_in & retire_had_we_in & (retire_wa_in == `REGAW'(r));
    end
  end

  // Scoreboard counters: saturate at both ends instead of wrapping
  always_ff @(posedge clk) begin
    for (int r = 0; r < NREGS; r++) begin
      if (rst) begin
        cnt_q[r] <= '0;
      end else if (inc[r] && !dec[r] && cnt_q[r] != CNT_MAX) begin
        cnt_q[r] <= cnt_q[r] + CNTW'(1);
      end else if (dec[r] && !inc[r] && cnt_q[r] != '0) begin
        cnt_q[r] <= cnt_q[r] - CNTW'(1);
      end
    end
  end

  // Flush FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      fc_q    <= '0;
    end else begin
      state_q <= state_d;
      fc_q    <= fc_d;
    end
  end

  // Flush FSM next state: a taken branch (re)starts the window
  always_comb begin
    state_d    = state_q;
    fc_d       = fc_q;
    flush_load = 1'b0;
    case (state_q)
      IDLE: begin
        if (branch_taken_in) begin
          state_d    = FLUSH;
          fc_d       = FC_LOAD;
          flush_load = 1'b1;
        end
      end
      FLUSH: begin
        if (branch_taken_in) begin
          fc_d       = FC_LOAD;
          flush_load = 1'b1;
        end else if (fc_q == 3'd0) begin
          state_d = IDLE;
        end else begin
          fc_d = fc_q - 3'd1;
        end
      end
      default: begin
        state_d = IDLE;
        fc_d    = '0;
      end
    endcase
  end

`ifdef HAZARD_STATS_EN
  logic [15:0] stall_cnt_q, flush_cnt_q;

  // Saturating stall-cycle and flush-event counters
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_out && stall_cnt_q != 16'hFFFF) stall_cnt_q <= stall_cnt_q + 16'd1;
      if (flush_load && flush_cnt_q != 16'hFFFF) flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign stall_cnt_out = stall_cnt_q;
  assign flush_cnt_out = flush_cnt_q;
`else
  assign stall_cnt_out = 16'h0;
  assign flush_cnt_out = 16'h0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
`timescale 1ns/1ps

module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid_in;
  logic [3:0]  rn_a_in, rm_a_in, rd_a_in;
  logic        use_rn_in, use_rm_in, use_rd_in, reg_we_in;
  logic        retire_valid_in;
  logic [3:0]  retire_wa_in;
  logic        retire_had_we_in;
  logic        branch_taken_in;
  logic        stall_out, flush_out, issue_fire_out;
  logic [15:0] stall_cnt_out, flush_cnt_out;

  int checks = 0;
  int errors = 0;

  hazard_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .issue_valid_in   (issue_valid_in),
    .rn_a_in          (rn_a_in),
    .rm_a_in          (rm_a_in),
    .rd_a_in          (rd_a_in),
    .use_rn_in        (use_rn_in),
    .use_rm_in        (use_rm_in),
    .use_rd_in        (use_rd_in),
    .reg_we_in        (reg_we_in),
    .retire_valid_in  (retire_valid_in),
    .retire_wa_in     (retire_wa_in),
    .retire_had_we_in (retire_had_we_in),
    .branch_taken_in  (branch_taken_in),
    .stall_out        (stall_out),
    .flush_out        (flush_out),
    .issue_fire_out   (issue_fire_out),
    .stall_cnt_out    (stall_cnt_out),
    .flush_cnt_out    (flush_cnt_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check stall/flush/fire together for the current cycle
  task automatic chk3(input string tag, input logic s, input logic f, input logic fi);
    chk({tag, ".stall"}, 32'(stall_out), 32'(s));
    chk({tag, ".flush"}, 32'(flush_out), 32'(f));
    chk({tag, ".fire"}, 32'(issue_fire_out), 32'(fi));
  endtask

  task automatic clr();
    issue_valid_in = 0; rn_a_in = 0; rm_a_in = 0; rd_a_in = 0;
    use_rn_in = 0; use_rm_in = 0; use_rd_in = 0; reg_we_in = 0;
    retire_valid_in = 0; retire_wa_in = 0; retire_had_we_in = 0;
    branch_taken_in = 0;
  endtask

  task automatic issue_wr(input logic [3:0] r);
    clr(); issue_valid_in = 1; reg_we_in = 1; rd_a_in = r;
  endtask

  task automatic issue_rn(input logic [3:0] r);
    clr(); issue_valid_in = 1; use_rn_in = 1; rn_a_in = r;
  endtask

  task automatic retire(input logic [3:0] r);
    retire_valid_in = 1; retire_wa_in = r; retire_had_we_in = 1;
  endtask

  // Advance one clock, leaving time just after the edge for new inputs
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    #1;
  endtask

  logic [15:0] exp_stall_pre, exp_flush_pre;

  initial begin
`ifdef HAZARD_STATS_EN
    exp_stall_pre = 16'd5 + 16'd4;
    exp_flush_pre = 16'd4;
`else
    exp_stall_pre = 16'd0;
    exp_flush_pre = 16'd0;
`endif
    clr();
    rst = 1;
    tick(); tick();
    rst = 0;
    settle();
    chk3("reset", 0, 0, 0);
    chk("reset.stall_cnt", 32'(stall_cnt_out), 0);
    chk("reset.flush_cnt", 32'(flush_cnt_out), 0);

    // 1: write r3, dependent read stalls until the cycle after retire
    issue_wr(3); settle(); chk3("t1.wr", 0, 0, 1); tick();
    issue_rn(3); settle(); chk3("t1.rd0", 1, 0, 0); tick();
    settle(); chk3("t1.rd1", 1, 0, 0); tick();
    retire(3); settle(); chk3("t1.rd_ret", 1, 0, 0); tick();
    issue_rn(3); settle(); chk3("t1.rd_go", 0, 0, 1); tick();
    // rm and rd-as-source paths, and an unused operand that must not stall
    issue_wr(9); settle(); chk3("t1.wr9", 0, 0, 1); tick();
    clr(); issue_valid_in = 1; use_rm_in = 1; rm_a_in = 9;
    settle(); chk3("t1.rm9", 1, 0, 0); tick();
    clr(); issue_valid_in = 1; use_rn_in = 1; rn_a_in = 0; rm_a_in = 9;
    settle(); chk3("t1.rm9_unused", 0, 0, 1); tick();
    clr(); issue_valid_in = 1; use_rd_in = 1; rd_a_in = 9;
    settle(); chk3("t1.rd9_store", 1, 0, 0); tick();
    clr(); retire(9); settle(); tick();

    // 2: single taken branch -> two flush cycles
    clr(); branch_taken_in = 1; settle(); chk("t2.c10", 32'(flush_out), 0); tick();
    clr(); settle(); chk("t2.c11", 32'(flush_out), 1); tick();
    settle(); chk("t2.c12", 32'(flush_out), 1); tick();
    settle(); chk("t2.c13", 32'(flush_out), 0); tick();

    // 3: second branch during the window restarts it
    branch_taken_in = 1; settle(); chk("t3.c10", 32'(flush_out), 0); tick();
    settle(); chk("t3.c11", 32'(flush_out), 1); tick();
    clr(); settle(); chk("t3.c12", 32'(flush_out), 1); tick();
    settle(); chk("t3.c13", 32'(flush_out), 1); tick();
    settle(); chk("t3.c14", 32'(flush_out), 0); tick();

    // 4: counter saturation on r5, WAW stall at max, no underflow wrap
    issue_wr(5); settle(); chk3("t4.w1", 0, 0, 1); tick();
    settle(); chk3("t4.w2", 0, 0, 1); tick();
    settle(); chk3("t4.w3", 0, 0, 1); tick();
    settle(); chk3("t4.w4", 1, 0, 0); tick();
    retire(5); settle(); chk3("t4.w4_ret", 1, 0, 0); tick();
    issue_wr(5); settle(); chk3("t4.w4_go", 0, 0, 1); tick();
    settle(); chk3("t4.still_max", 1, 0, 0); tick();
    clr(); retire(5); settle(); tick();
    settle(); tick();
    issue_rn(5); retire(5); settle(); chk3("t4.rd_last", 1, 0, 0); tick();
    issue_rn(5); settle(); chk3("t4.rd_free", 0, 0, 1); tick();
    clr(); retire(5); settle(); tick();
    issue_rn(5); settle(); chk3("t4.no_wrap", 0, 0, 1); tick();

    // 5: hazard during flush -> flush wins, nothing issued or counted
    issue_wr(7); settle(); chk3("t5.wr7", 0, 0, 1); tick();
    clr(); branch_taken_in = 1; settle(); tick();
    clr(); issue_valid_in = 1; use_rn_in = 1; rn_a_in = 7; reg_we_in = 1; rd_a_in = 7;
    settle(); chk3("t5.f1", 0, 1, 0); tick();
    settle(); chk3("t5.f2", 0, 1, 0); tick();
    clr(); retire(7); settle(); chk3("t5.ret7", 0, 0, 0); tick();
    issue_rn(7); settle(); chk3("t5.cnt_kept", 0, 0, 1); tick();

    // 6: reset mid-flush with r2 pending clears everything
    clr(); settle();
    chk("t6.pre_stall_cnt", 32'(stall_cnt_out), 32'(exp_stall_pre));
    chk("t6.pre_flush_cnt", 32'(flush_cnt_out), 32'(exp_flush_pre));
    issue_wr(2); settle(); chk3("t6.wr2", 0, 0, 1); tick();
    clr(); branch_taken_in = 1; settle(); tick();
    clr(); rst = 1; settle(); chk("t6.in_flush", 32'(flush_out), 1); tick();
    rst = 0;
    issue_rn(2); settle(); chk3("t6.after_rst", 0, 0, 1);
    chk("t6.stall_cnt", 32'(stall_cnt_out), 0);
    chk("t6.flush_cnt", 32'(flush_cnt_out), 0);
    tick();
    clr();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
